// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment encodings,
// brightness phase count and the scan sequencer state type.
package seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam int         NUM_PHASES = 16;

  // Active-low gfedcba patterns, entry 15 (F) first so SEG_HEX[n] is digit n.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_scan_ctrl_hex.sv
// Hex nibble to active-low 7-segment pattern, purely combinational.
module seg_hex_decoder
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_HEX[nib_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with PWM brightness,
// anti-ghost blanking, leading-zero suppression and per-frame snapshots.
//
// state   | meaning
// ST_INIT | first cycle after reset release: take the initial snapshot
// ST_SCAN | free-running cyc/phase/digit scan, snapshot on digit wrap
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int PHASE_CYC  = 390
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   mask_i,
  input  logic [3:0]              bright_i,
  input  logic                    lz_en_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   en_o,
  output logic                    frame_o
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

  scan_state_e             state_q, state_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [3:0]              phase_q, phase_d;
  logic [DW-1:0]           dig_q, dig_d;
  logic                    snap_take;

  logic [4*NUM_DIGITS-1:0] data_s_q;
  logic [NUM_DIGITS-1:0]   dp_s_q, mask_s_q;
  logic [3:0]              bright_s_q;
  logic                    lz_s_q;

  logic [6:0]              seg_q, seg_d, seg_dec;
  logic                    dp_q, dp_d, frame_q;
  logic [NUM_DIGITS-1:0]   en_q, en_d, sup;
  logic                    zero_run, digit_on;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    phase_d   = phase_q;
    dig_d     = dig_q;
    snap_take = 1'b0;
    case (state_q)
      ST_INIT: begin
        snap_take = 1'b1;
        state_d   = ST_SCAN;
      end
      ST_SCAN: begin
        if (cyc_q == CW'(PHASE_CYC - 1)) begin
          cyc_d   = '0;
          phase_d = phase_q + 4'd1;
          if (phase_q == 4'(NUM_PHASES - 1)) begin
            if (dig_q == DW'(NUM_DIGITS - 1)) begin
              dig_d     = '0;
              snap_take = 1'b1;
            end else begin
              dig_d = dig_q + DW'(1);
            end
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // A digit is suppressed when it and every digit to its left is a bare zero.
  always_comb begin
    sup      = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (data_s_q[4*k +: 4] == 4'h0) & ~dp_s_q[k];
      sup[k]   = lz_s_q & zero_run;
    end
  end

  seg_hex_decoder u_dec (
    .nib_i (data_s_q[{dig_q, 2'b00} +: 4]),
    .seg_o (seg_dec)
  );

  assign digit_on = (phase_q != 4'd0) && (phase_q <= bright_s_q) &&
                    !mask_s_q[dig_q] && !sup[dig_q];

  always_comb begin
    en_d = '1;
    if (digit_on) en_d[dig_q] = 1'b0;
    seg_d = digit_on ? seg_dec : SEG_BLANK;
    dp_d  = digit_on ? ~dp_s_q[dig_q] : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cyc_q      <= '0;
      phase_q    <= '0;
      dig_q      <= '0;
      data_s_q   <= '0;
      dp_s_q     <= '0;
      mask_s_q   <= '0;
      bright_s_q <= '0;
      lz_s_q     <= 1'b0;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      en_q       <= '1;
      frame_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      phase_q <= phase_d;
      dig_q   <= dig_d;
      if (snap_take) begin
        data_s_q   <= data_i;
        dp_s_q     <= dp_i;
        mask_s_q   <= mask_i;
        bright_s_q <= bright_i;
        lz_s_q     <= lz_en_i;
      end
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      frame_q <= snap_take;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign en_o    = en_q;
  assign frame_o = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (4 digits, 2 cycles per phase) with a
// per-cycle reference model feeding an expected-output queue.
module tb_seg_scan_ctrl;

  localparam int ND   = 4;
  localparam int PC   = 2;
  localparam int SLOT = 16 * PC;
  localparam int FRM  = SLOT * ND;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [15:0]   data_i = 16'hFFFF;
  logic [3:0]    dp_i = 4'hF, mask_i = 4'h5, bright_i = 4'h9;
  logic          lz_en_i = 1'b1;
  logic [6:0]    seg_o;
  logic          dp_o, frame_o;
  logic [3:0]    en_o;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .PHASE_CYC(PC)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .dp_i(dp_i), .mask_i(mask_i),
    .bright_i(bright_i), .lz_en_i(lz_en_i), .seg_o(seg_o), .dp_o(dp_o),
    .en_o(en_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  logic [6:0] tb_hex [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int total = 0, bad = 0;
  int n = 0, lows_acc = 0, last_lows = -1;
  logic [15:0] m_data;
  logic [3:0]  m_dp, m_mask, m_bright;
  logic        m_lz;
  logic [12:0] sb [$];

  // Expected {en, dp, seg} for scan position t (cycles since scan start).
  function automatic logic [11:0] model_out(int t);
    int dig, ph;
    logic zr, sp, on;
    logic [3:0] en;
    dig = (t / SLOT) % ND;
    ph  = (t / PC) % 16;
    zr  = 1'b1;
    for (int k = dig; k < ND; k++)
      if (m_data[4*k +: 4] != 4'h0 || m_dp[k]) zr = 1'b0;
    sp = m_lz && (dig != 0) && zr;
    on = (ph != 0) && (ph <= int'(m_bright)) && !m_mask[dig] && !sp;
    en = 4'hF;
    if (on) en[dig] = 1'b0;
    return on ? {en, ~m_dp[dig], tb_hex[m_data[4*dig +: 4]]} : {4'hF, 1'b1, 7'h7F};
  endfunction

  task automatic step();
    logic [12:0] e, o;
    int nt;
    @(posedge clk);
    nt = n;
    if (nt == 0) e = {1'b1, 4'hF, 1'b1, 7'h7F};
    else         e = {(nt % FRM == 0), model_out(nt - 1)};
    if (nt % FRM == 0) begin
      m_data = data_i; m_dp = dp_i; m_mask = mask_i; m_bright = bright_i; m_lz = lz_en_i;
    end
    n++;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    o = {frame_o, en_o, dp_o, seg_o};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL scan n=%0d observed=%h expected=%h", nt, o, e);
    end
    if (en_o !== 4'hF) lows_acc++;
    if (nt == 0) lows_acc = 0;
    else if (e[12]) begin
      last_lows = lows_acc;
      lows_acc  = 0;
    end
  endtask

  task automatic run_to(int target);
    while (n < target) step();
  endtask

  task automatic check_dark(string tag);
    total++;
    assert ({frame_o, en_o, dp_o, seg_o} === {1'b0, 4'hF, 1'b1, 7'h7F}) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, {frame_o, en_o, dp_o, seg_o},
             {1'b0, 4'hF, 1'b1, 7'h7F});
    end
  endtask

  task automatic check_lows(string tag, int expected);
    total++;
    assert (last_lows == expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, last_lows, expected);
    end
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    lows_acc = 0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 check_dark("reset_async");
    repeat (3) @(negedge clk);
    check_dark("reset_hold");

    data_i = 16'h1A08; dp_i = 4'h0; mask_i = 4'h0; bright_i = 4'd15; lz_en_i = 1'b0;
    release_rst();
    run_to(64);  bright_i = 4'd4;
    run_to(129); check_lows("lows_bright15", 120);
    run_to(200); bright_i = 4'd0;
    run_to(257); check_lows("lows_bright4", 32);
    run_to(300); bright_i = 4'd15; mask_i = 4'b0010; dp_i = 4'b0100;
    run_to(385); check_lows("lows_bright0", 0);
    run_to(450); lz_en_i = 1'b1; data_i = 16'h0005; dp_i = 4'h0; mask_i = 4'h0;
    run_to(513); check_lows("lows_mask_dp", 90);
    run_to(600); data_i = 16'h0000;
    run_to(641); check_lows("lows_lz_0005", 30);
    run_to(700); data_i = 16'h0005; dp_i = 4'b0100;
    run_to(769); check_lows("lows_lz_0000", 30);
    run_to(850); lz_en_i = 1'b0; data_i = 16'h1234; dp_i = 4'h0;
    run_to(897); check_lows("lows_lz_dp", 90);
    run_to(940); data_i = 16'h5678;
    run_to(1025); check_lows("lows_snap_1234", 120);
    run_to(1100);

    @(posedge clk);
    #3 rst_n = 1'b0;
    data_i = 16'hCD9E; bright_i = 4'd15; dp_i = 4'b1001; mask_i = 4'h0;
    #1 check_dark("reset_midframe");
    repeat (2) @(negedge clk);
    check_dark("reset_midframe_hold");
    release_rst();
    run_to(60);  data_i = 16'hF9EB; bright_i = 4'd1;
    run_to(129); check_lows("lows_after_reset", 120);
    run_to(257); check_lows("lows_bright1", 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
